// File: rtl/postcode_sched.sv
// postcode_sched: buffers LPC port-80/81 POST-code writes and hands
// them one at a time to the QSPI slave, with interrupt re-arm on stall.
module postcode_sched #(
   parameter int DEPTH        = 16,
   parameter int INT_TIMEOUT  = 65535,
   parameter int REARM_CYCLES = 4
) (
   input  logic                     lpc_clk_l,
   input  logic                     lpc_rst,
   input  logic                     lpc_hit,
   input  logic [7:0]               port_80,
   input  logic [7:0]               port_81,
   input  logic                     xfer_done,
   input  logic                     clear_ovf,
   output logic [7:0]               out_80,
   output logic [7:0]               out_81,
   output logic                     out_valid,
   output logic                     qspi_int,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(INT_TIMEOUT);
   localparam int RW = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;

   localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(INT_TIMEOUT - 1);
   localparam logic [RW-1:0] RA_LAST  = RW'(REARM_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ASSERT,
      REARM,
      POP
   } state_t;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          hit_q;
   state_t        state;
   logic [TW-1:0] tmr;
   logic [RW-1:0] rcnt;

   logic push;
   logic full;
   logic do_push;
   logic do_pop;

   assign push    = lpc_hit & ~hit_q;
   assign full    = (fifo_count == FULL);
   assign do_push = push & ~full;
   assign do_pop  = (state == POP);

   always_ff @(posedge lpc_clk_l) begin
      if (do_push)
         mem[wr_ptr] <= {port_81, port_80};
   end

   always_ff @(posedge lpc_clk_l or posedge lpc_rst) begin
      if (lpc_rst) begin
         hit_q      <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         hit_q <= lpc_hit;
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
         // a drop wins over a same-cycle clear
         if (push && full)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge lpc_clk_l or posedge lpc_rst) begin
      if (lpc_rst) begin
         state     <= IDLE;
         out_80    <= '0;
         out_81    <= '0;
         out_valid <= 1'b0;
         qspi_int  <= 1'b0;
         tmr       <= '0;
         rcnt      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               out_valid <= 1'b0;
               qspi_int  <= 1'b0;
               if (fifo_count != '0)
                  state <= LOAD;
            end
            LOAD: begin
               {out_81, out_80} <= mem[rd_ptr];
               out_valid        <= 1'b1;
               qspi_int         <= 1'b1;
               tmr              <= '0;
               state            <= ASSERT;
            end
            ASSERT: begin
               if (xfer_done) begin
                  state     <= POP;
                  qspi_int  <= 1'b0;
                  out_valid <= 1'b0;
               end else if (tmr == TMO_LAST) begin
                  state    <= REARM;
                  qspi_int <= 1'b0;
                  rcnt     <= '0;
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
            REARM: begin
               // a late read still retires the entry
               if (xfer_done) begin
                  state     <= POP;
                  qspi_int  <= 1'b0;
                  out_valid <= 1'b0;
               end else if (rcnt == RA_LAST) begin
                  state    <= ASSERT;
                  qspi_int <= 1'b1;
                  tmr      <= '0;
               end else begin
                  rcnt <= rcnt + RW'(1);
               end
            end
            POP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_postcode_sched.sv
// Bench for postcode_sched: vector table, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_postcode_sched;

   localparam int DEPTH = 4;
   localparam int TO    = 8;
   localparam int RC    = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       hit;
   logic [7:0] p80;
   logic [7:0] p81;
   logic       xd;
   logic       clr;
   logic [7:0] o80;
   logic [7:0] o81;
   logic       ov;
   logic       qi;
   logic [2:0] cnt;
   logic       ovf;

   int checks   = 0;
   int failures = 0;

   postcode_sched #(
      .DEPTH(DEPTH),
      .INT_TIMEOUT(TO),
      .REARM_CYCLES(RC)
   ) dut (
      .lpc_clk_l(clk),
      .lpc_rst(rst),
      .lpc_hit(hit),
      .port_80(p80),
      .port_81(p81),
      .xfer_done(xd),
      .clear_ovf(clr),
      .out_80(o80),
      .out_81(o81),
      .out_valid(ov),
      .qspi_int(qi),
      .fifo_count(cnt),
      .overflow(ovf)
   );

   always #5 clk = ~clk;

   // reference model: queue of buffered codes plus presentation phase
   logic [15:0] mq[$];
   bit          mhit_q;
   bit          movf;
   int          mph;
   int          mel;
   logic [15:0] mout;

   task automatic model_reset();
      mq.delete();
      mhit_q = 0;
      movf   = 0;
      mph    = 0;
      mel    = 0;
      mout   = '0;
   endtask

   task automatic model_step(input bit h, input logic [7:0] a,
                             input logic [7:0] b, input bit x,
                             input bit c);
      int sz;
      bit rise;
      bit drop;
      sz   = mq.size();
      rise = h && !mhit_q;
      drop = rise && (sz == DEPTH);
      case (mph)
         0: if (sz != 0) mph = 1;
         1: begin mout = mq[0]; mph = 2; mel = 0; end
         2: if (x) mph = 3; else mel++;
         default: begin void'(mq.pop_front()); mph = 0; end
      endcase
      if (rise && !drop)
         mq.push_back({b, a});
      if (drop)
         movf = 1;
      else if (c)
         movf = 0;
      mhit_q = h;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit h, input logic [7:0] a,
                      input logic [7:0] b, input bit x, input bit c);
      bit eint;
      @(negedge clk);
      hit = h; p80 = a; p81 = b; xd = x; clr = c;
      eint = (mph == 2) && ((mel % (TO + RC)) < TO);
      chk("model", {10'd0, qi, ov, cnt, ovf, o81, o80},
          {10'd0, eint, (mph == 2), 3'(mq.size()), movf, mout});
      model_step(h, a, b, x, c);
   endtask

   task automatic idle();
      cyc(0, 8'h00, 8'h00, 0, 0);
   endtask

   task automatic push(input logic [7:0] a);
      cyc(1, a, 8'h00, 0, 0);
      idle();
   endtask

   task automatic wait_int(output int n);
      n = 0;
      do begin
         idle();
         n++;
      end while (!qi && n < 60);
      chk("wait_int", {31'd0, qi}, 32'd1);
   endtask

   typedef struct {
      bit         h;
      logic [7:0] a;
      logic [7:0] b;
      bit         x;
      bit         e_int;
      bit         e_val;
      int         e_cnt;
      logic [7:0] e_o80;
      logic [7:0] e_o81;
   } vec_t;

   vec_t        tbl[8];
   logic [7:0]  expq[$];
   int          n;

   initial begin
      tbl[0] = '{1, 8'hA5, 8'h01, 0, 0, 0, 0, 8'h00, 8'h00};
      tbl[1] = '{1, 8'hA5, 8'h01, 0, 0, 0, 1, 8'h00, 8'h00};
      tbl[2] = '{1, 8'hA5, 8'h01, 0, 0, 0, 1, 8'h00, 8'h00};
      tbl[3] = '{0, 8'h00, 8'h00, 0, 1, 1, 1, 8'hA5, 8'h01};
      tbl[4] = '{0, 8'h00, 8'h00, 1, 1, 1, 1, 8'hA5, 8'h01};
      tbl[5] = '{0, 8'h00, 8'h00, 0, 0, 0, 1, 8'hA5, 8'h01};
      tbl[6] = '{0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h01};
      tbl[7] = '{0, 8'h00, 8'h00, 0, 0, 0, 0, 8'hA5, 8'h01};

      rst = 1; hit = 0; p80 = 0; p81 = 0; xd = 0; clr = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset", {10'd0, qi, ov, cnt, ovf, o81, o80}, 32'd0);
      rst = 0;

      // single capture, cycle by cycle
      for (int i = 0; i < 8; i++) begin
         cyc(tbl[i].h, tbl[i].a, tbl[i].b, tbl[i].x, 0);
         chk("tbl", {qi, ov, cnt, o81, o80},
             {tbl[i].e_int, tbl[i].e_val, 3'(tbl[i].e_cnt),
              tbl[i].e_o81, tbl[i].e_o80});
      end

      // timeout / re-arm pattern, xfer_done in a low phase
      push(8'h33);
      wait_int(n);
      for (int i = 1; i <= 38; i++) begin
         cyc(0, 8'h00, 8'h00, (i == 38), 0);
         chk("tmo_int", {31'd0, qi}, {31'd0, ((i % 10) < 8)});
         if (i == 25)
            chk("tmo_out", {24'd0, o80}, 32'h33);
      end
      idle();
      chk("tmo_pop_valid", {31'd0, ov}, 32'd0);
      idle();
      chk("tmo_pop_cnt", {29'd0, cnt}, 32'd0);

      // ordering and re-assert latency
      push(8'h10); push(8'h11); push(8'h12);
      wait_int(n);
      for (int i = 0; i < 3; i++) begin
         chk("order", {24'd0, o80}, 32'h10 + i);
         cyc(0, 8'h00, 8'h00, 1, 0);
         if (i < 2) begin
            wait_int(n);
            chk("reint", n, 32'd4);
         end
      end
      idle(); idle();
      chk("order_cnt", {29'd0, cnt}, 32'd0);

      // overflow
      for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
      chk("ovf_cnt", {29'd0, cnt}, 32'd4);
      chk("ovf_set", {31'd0, ovf}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         wait_int(n);
         chk("ovf_order", {24'd0, o80}, 32'h20 + i);
         cyc(0, 8'h00, 8'h00, 1, 0);
      end
      idle(); idle();
      chk("ovf_drain", {29'd0, cnt}, 32'd0);
      chk("ovf_hold", {31'd0, ovf}, 32'd1);
      cyc(0, 8'h00, 8'h00, 0, 1);
      idle();
      chk("ovf_clr", {31'd0, ovf}, 32'd0);

      // simultaneous push and pop, then pointer wrap
      push(8'h40); push(8'h41);
      wait_int(n);
      chk("pp_cnt0", {29'd0, cnt}, 32'd2);
      expq = '{8'h41, 8'h42};
      cyc(0, 8'h00, 8'h00, 1, 0);
      cyc(1, 8'h42, 8'h00, 0, 0);
      idle();
      chk("pp_cnt", {29'd0, cnt}, 32'd2);
      for (int j = 0; j < 3 * DEPTH; j++) begin
         push(8'h50 + 8'(j));
         expq.push_back(8'h50 + 8'(j));
         wait_int(n);
         chk("wrap", {24'd0, o80}, {24'd0, expq.pop_front()});
         cyc(0, 8'h00, 8'h00, 1, 0);
      end
      while (expq.size() != 0) begin
         wait_int(n);
         chk("wrap", {24'd0, o80}, {24'd0, expq.pop_front()});
         cyc(0, 8'h00, 8'h00, 1, 0);
      end
      idle(); idle();
      chk("wrap_cnt", {29'd0, cnt}, 32'd0);

      // asynchronous reset while asserting
      push(8'h60); push(8'h61); push(8'h62);
      wait_int(n);
      chk("rst_pre", {29'd0, cnt}, 32'd3);
      #2 rst = 1;
      #1;
      chk("rst_async", {10'd0, qi, ov, cnt, ovf, o81, o80}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 0;
      push(8'h7E);
      wait_int(n);
      chk("rst_first", {24'd0, o80}, 32'h7E);
      cyc(0, 8'h00, 8'h00, 1, 0);
      idle(); idle();
      chk("rst_cnt", {29'd0, cnt}, 32'd0);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/postcode_sched.md
# postcode_sched

Sequencing controller between the LPC port-80/81 decoder and the QSPI slave. Captures each decoded POST-code write into a small FIFO, presents one entry at a time to the QSPI slave, and raises the QSPI interrupt. It then holds that entry stable until the host signals the read is complete, and re-arms the interrupt if the host stalls. Runs entirely in the LPC clock domain.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥2.
- INT_TIMEOUT, 65535: cycles qspi_int stays high without xfer_done before re-arm; ≥2.
- REARM_CYCLES, 4: cycles qspi_int is forced low during a re-arm; ≥1.

Ports:
- lpc_clk_l  in  1  system clock (LPC clock); all logic on its rising edge.
- lpc_rst  in  1  asynchronous, active-high reset.
- lpc_hit  in  1  decoder write-hit; level, may stay high for several cycles.
- port_80  in  8  decoder port-80 byte; valid while lpc_hit is high.
- port_81  in  8  decoder port-81 byte; valid while lpc_hit is high.
- xfer_done  in  1  single-cycle pulse, already synchronized to lpc_clk_l: host finished reading the presented entry.
- clear_ovf  in  1  single-cycle pulse; clears overflow.
- out_80  out  8  presented port-80 byte.
- out_81  out  8  presented port-81 byte.
- out_valid  out  1  out_80/out_81 hold a presented entry.
- qspi_int  out  1  interrupt to the host, registered.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.
- overflow  out  1  sticky flag: a capture was dropped because the FIFO was full.

## Operation
- Reset values: out_80=0, out_81=0, out_valid=0, qspi_int=0, fifo_count=0, overflow=0. Pointers and timers are 0; state is IDLE.
- Capture: hit_q is lpc_hit delayed by one cycle. Push {port_81, port_80} when lpc_hit=1 and hit_q=0, so there is exactly one push per hit pulse.
- Full: a push while fifo_count==DEPTH is dropped and sets overflow. FIFO contents and count are unchanged.
- Overflow flag: clear_ovf clears overflow. If a drop and clear_ovf occur in the same cycle, overflow stays set.
- Pointers: read/write pointers are $clog2(DEPTH) bits and wrap naturally.
- Simultaneous push and pop: both take effect and fifo_count is unchanged.
- FSM states:
  - IDLE: out_valid=0, qspi_int=0. If fifo_count≠0, go to LOAD.
  - LOAD (1 cycle): register the FIFO head into out_80/out_81, set out_valid=1, go to ASSERT.
  - ASSERT: qspi_int=1 and the timeout counter increments each cycle.
    - On xfer_done, go to POP.
    - Otherwise, when the counter reaches INT_TIMEOUT−1, go to REARM.
  - REARM: qspi_int=0, out_valid stays 1, outputs unchanged. After REARM_CYCLES cycles, return to ASSERT with the timeout counter cleared.
    - xfer_done seen in REARM goes to POP; a late read still completes the entry.
  - POP (1 cycle): qspi_int=0, out_valid=0, advance the read pointer, go to IDLE.
- xfer_done in IDLE, LOAD or POP is ignored.
- out_80/out_81 change only in LOAD. They keep their last value after POP.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous); buffered entries are discarded.

## Timing
- lpc_hit rises in cycle 0 with the FIFO empty and FSM in IDLE:
  - fifo_count=1 from cycle 1.
  - LOAD in cycle 2; out_valid=1 from cycle 3.
  - qspi_int=1 from cycle 3.
- xfer_done in cycle k while in ASSERT:
  - qspi_int=0 and out_valid=0 from cycle k+1 (POP).
  - fifo_count decrements at k+2.
  - If more entries remain, qspi_int reasserts at k+4.
- Back-to-back service interval, once xfer_done is seen: 3 cycles with qspi_int low (POP, IDLE, LOAD).
- Timeout: qspi_int is high for exactly INT_TIMEOUT cycles, then low for REARM_CYCLES cycles, repeating until xfer_done.
- Throughput: one capture per 2 cycles minimum (lpc_hit must drop for ≥1 cycle between hits).

## Test plan
- Single capture: reset, then lpc_hit high 3 cycles with port_80=0xA5, port_81=0x01 → out_80=0xA5, out_81=0x01, qspi_int high at cycle 3. Pulse xfer_done → qspi_int low next cycle, fifo_count=0.
- Ordering: push 0x10, 0x11, 0x12 before any xfer_done → presented in order 0x10, 0x11, 0x12; qspi_int reasserts 4 cycles after each xfer_done.
- Overflow with DEPTH=4: push 5 codes (0x20–0x24) with no xfer_done → fifo_count=4, overflow=1, drained order 0x20–0x23. clear_ovf → overflow=0.
- Timeout with INT_TIMEOUT=8, REARM_CYCLES=2: present 0x33 with no xfer_done → qspi_int pattern 8 high / 2 low repeated, out_80 stays 0x33. xfer_done during a low phase → POP.
- Simultaneous push and pop at fifo_count=2 → fifo_count stays 2; the pointer wrap past DEPTH is exercised with 3×DEPTH codes in and out, none lost.
- Async reset asserted in ASSERT with 3 entries buffered → all outputs 0 immediately. After release, a new capture 0x7E is presented first.
